// File: rtl/flex_counter_pkg.sv
// Shared types and next-state helper for the multi-channel flex counter.
// Arithmetic is done at CALC_W and truncated by each channel.
package flex_counter_pkg;

   localparam int unsigned CALC_W = 32;

   typedef struct packed {
      logic clear;
      logic count_enable;
      logic count_down;
      logic saturate;
      logic cascade;
   } ch_ctrl_t;

   typedef struct packed {
      logic [CALC_W-1:0] next;
      logic              wrap;
   } nc_t;

   function automatic nc_t next_count(
      input logic [CALC_W-1:0] c,
      input logic [CALC_W-1:0] r,
      input logic              down,
      input logic              sat
   );
      nc_t res;
      res.next = c;
      res.wrap = 1'b0;
      if (r == '0) begin
         res.next = '0;
      end else if (!down) begin
         if (c >= r) begin
            res.next = sat ? r : CALC_W'(1);
            res.wrap = !sat;
         end else begin
            res.next = c + CALC_W'(1);
         end
      end else if (sat) begin
         res.next = (c == '0) ? '0 : c - CALC_W'(1);
      end else if (c <= CALC_W'(1)) begin
         res.next = r;
         res.wrap = 1'b1;
      end else begin
         res.next = c - CALC_W'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count register, next-state, flag and wrap pulse.
// wrap_evt_o is combinational so a cascaded successor advances on the same edge.
module flex_counter_ch
   import flex_counter_pkg::*;
#(
   parameter int NUM_BITS = 4,
   parameter bit FIRST    = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  ch_ctrl_t            ctrl_i,
   input  logic                prev_wrap_i,
   input  logic [NUM_BITS-1:0] rollover_val_i,
   output logic [NUM_BITS-1:0] count_o,
   output logic                rollover_flag_o,
   output logic                wrap_evt_o,
   output logic                wrap_pulse_o
);

   logic [NUM_BITS-1:0] count_q, count_d;
   logic                wrap_pulse_q, wrap_pulse_d;
   logic                en;
   nc_t                 nc;
   logic [NUM_BITS-1:0] nxt;
   logic [CALC_W-NUM_BITS-1:0] unused_hi;

   assign en = (ctrl_i.cascade && !FIRST) ? prev_wrap_i
                                          : ctrl_i.count_enable;

   assign nc = next_count(CALC_W'(count_q), CALC_W'(rollover_val_i),
                          ctrl_i.count_down, ctrl_i.saturate);
   assign {unused_hi, nxt} = nc.next;

   assign wrap_evt_o = en && !ctrl_i.clear && nc.wrap;

   always_comb begin
      count_d      = count_q;
      wrap_pulse_d = wrap_evt_o;
      if (ctrl_i.clear) begin
         count_d = '0;
      end else if (en) begin
         count_d = nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q      <= '0;
         wrap_pulse_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         wrap_pulse_q <= wrap_pulse_d;
      end
   end

   assign count_o         = count_q;
   assign wrap_pulse_o    = wrap_pulse_q;
   assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/multi_flex_counter.sv
// NUM_CH independent flex counters with optional cascade from the
// previous channel's wrap event.
module multi_flex_counter
   import flex_counter_pkg::*;
#(
   parameter int NUM_BITS = 4,
   parameter int NUM_CH   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                clear,
   input  logic [NUM_CH-1:0]                count_enable,
   input  logic [NUM_CH-1:0]                count_down,
   input  logic [NUM_CH-1:0]                saturate,
   input  logic [NUM_CH-1:0]                cascade,
   input  logic [NUM_CH-1:0][NUM_BITS-1:0]  rollover_val,
   output logic [NUM_CH-1:0][NUM_BITS-1:0]  count_out,
   output logic [NUM_CH-1:0]                rollover_flag,
   output logic [NUM_CH-1:0]                wrap_pulse
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_ctrl_t ctrl;
      logic     prev_wrap;
      logic     wrap_evt;

      assign ctrl = '{clear:        clear[i],
                      count_enable: count_enable[i],
                      count_down:   count_down[i],
                      saturate:     saturate[i],
                      cascade:      cascade[i]};

      if (i == 0) begin : g_head
         assign prev_wrap = 1'b0;
      end else begin : g_link
         assign prev_wrap = g_ch[i-1].wrap_evt;
      end

      // The last channel's wrap event has no successor to feed.
      if (i == NUM_CH-1) begin : g_tail
         logic unused_wrap;
         assign unused_wrap = wrap_evt;
      end

      flex_counter_ch #(
         .NUM_BITS (NUM_BITS),
         .FIRST    (i == 0)
      ) u_ch (
         .clk             (clk),
         .rst             (rst),
         .ctrl_i          (ctrl),
         .prev_wrap_i     (prev_wrap),
         .rollover_val_i  (rollover_val[i]),
         .count_o         (count_out[i]),
         .rollover_flag_o (rollover_flag[i]),
         .wrap_evt_o      (wrap_evt),
         .wrap_pulse_o    (wrap_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Directed bench for multi_flex_counter with a per-cycle behavioural
// model and hand-computed literal expectations.
module tb_multi_flex_counter;

   localparam int NB = 4;
   localparam int NC = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NC-1:0]          clear = '0;
   logic [NC-1:0]          count_enable = '0;
   logic [NC-1:0]          count_down = '0;
   logic [NC-1:0]          saturate = '0;
   logic [NC-1:0]          cascade = '0;
   logic [NC-1:0][NB-1:0]  rollover_val;
   logic [NC-1:0][NB-1:0]  count_out;
   logic [NC-1:0]          rollover_flag;
   logic [NC-1:0]          wrap_pulse;

   int errors = 0;
   int checks = 0;

   int m_cnt [NC];
   bit m_wp  [NC];

   multi_flex_counter #(.NUM_BITS(NB), .NUM_CH(NC)) dut (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .count_enable  (count_enable),
      .count_down    (count_down),
      .saturate      (saturate),
      .cascade       (cascade),
      .rollover_val  (rollover_val),
      .count_out     (count_out),
      .rollover_flag (rollover_flag),
      .wrap_pulse    (wrap_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: plain per-channel rules, evaluated channel 0 upward so a
   // wrap in channel i-1 can advance a cascaded channel i this edge.
   always @(posedge clk or posedge rst) begin
      bit evt [NC];
      bit en;
      int r;
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_wp[i]  = 0;
         end
      end else begin
         for (int i = 0; i < NC; i++) begin
            r      = int'(rollover_val[i]);
            en     = (i > 0 && cascade[i]) ? evt[i-1] : count_enable[i];
            evt[i] = 0;
            if (clear[i]) begin
               m_cnt[i] = 0;
            end else if (en) begin
               if (r == 0) begin
                  m_cnt[i] = 0;
               end else if (!count_down[i]) begin
                  if (m_cnt[i] >= r) begin
                     m_cnt[i] = saturate[i] ? r : 1;
                     evt[i]   = !saturate[i];
                  end else begin
                     m_cnt[i] = m_cnt[i] + 1;
                  end
               end else if (saturate[i]) begin
                  m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
               end else if (m_cnt[i] <= 1) begin
                  m_cnt[i] = r;
                  evt[i]   = 1;
               end else begin
                  m_cnt[i] = m_cnt[i] - 1;
               end
            end
            m_wp[i] = evt[i];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         chk($sformatf("model_cnt%0d", i), int'(count_out[i]), m_cnt[i]);
         chk($sformatf("model_wp%0d", i), int'(wrap_pulse[i]), int'(m_wp[i]));
         chk($sformatf("model_flag%0d", i), int'(rollover_flag[i]),
             int'(m_cnt[i] == int'(rollover_val[i])));
      end
   end

   initial begin
      int up_seq [6] = '{1, 2, 3, 4, 5, 1};
      int up_wp  [6] = '{0, 0, 0, 0, 0, 1};
      int dn_seq [3] = '{1, 5, 4};
      int dn_wp  [3] = '{0, 1, 0};
      int c1_seq [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 1, 1, 1};

      rollover_val[0] = 4'd5;
      rollover_val[1] = 4'd2;
      #12;
      chk("rst_cnt0", int'(count_out[0]), 0);
      chk("rst_wp", int'(wrap_pulse), 0);
      chk("rst_flag0", int'(rollover_flag[0]), 0);

      tick();
      rst = 1'b0;
      count_enable[0] = 1'b1;
      repeat (3) tick();
      chk("pre_areset_cnt0", int'(count_out[0]), 3);
      #2 rst = 1'b1;
      #1;
      chk("areset_cnt0", int'(count_out[0]), 0);
      chk("areset_wp", int'(wrap_pulse), 0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("post_rst_cnt0", int'(count_out[0]), 5);
      chk("post_rst_flag0", int'(rollover_flag[0]), 1);

      count_enable[0] = 1'b0;
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      count_enable[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("upwrap_cnt", int'(count_out[0]), up_seq[k]);
         chk("upwrap_wp", int'(wrap_pulse[0]), up_wp[k]);
         chk("upwrap_flag", int'(rollover_flag[0]), int'(up_seq[k] == 5));
      end

      tick();
      chk("to2_cnt", int'(count_out[0]), 2);
      count_down[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dnwrap_cnt", int'(count_out[0]), dn_seq[k]);
         chk("dnwrap_wp", int'(wrap_pulse[0]), dn_wp[k]);
      end
      count_down[0] = 1'b0;
      saturate[0] = 1'b1;
      repeat (3) begin
         tick();
         chk("upsat_cnt", int'(count_out[0]), 5);
         chk("upsat_wp", int'(wrap_pulse[0]), 0);
      end
      count_down[0] = 1'b1;
      repeat (4) tick();
      chk("dnsat_pre", int'(count_out[0]), 1);
      repeat (2) begin
         tick();
         chk("dnsat_cnt", int'(count_out[0]), 0);
         chk("dnsat_wp", int'(wrap_pulse[0]), 0);
      end
      saturate[0] = 1'b0;
      count_down[0] = 1'b0;
      count_enable[0] = 1'b0;

      clear = 2'b11;
      tick();
      clear = 2'b00;
      rollover_val[0] = 4'd3;
      rollover_val[1] = 4'd2;
      cascade = 2'b10;
      count_enable[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         count_enable[1] = k[0];
         tick();
         chk("casc_cnt0", int'(count_out[0]), (k % 3) + 1);
         chk("casc_wp0", int'(wrap_pulse[0]), int'(k > 0 && k % 3 == 0));
         chk("casc_cnt1", int'(count_out[1]), c1_seq[k]);
         chk("casc_wp1", int'(wrap_pulse[1]), int'(k == 9));
      end
      count_enable = 2'b00;
      cascade = 2'b00;

      rollover_val[0] = 4'd5;
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      count_enable[0] = 1'b1;
      repeat (4) tick();
      chk("clr_pre", int'(count_out[0]), 4);
      clear[0] = 1'b1;
      tick();
      chk("clr_vs_en", int'(count_out[0]), 0);
      clear[0] = 1'b0;

      rollover_val[0] = 4'd0;
      repeat (3) begin
         tick();
         chk("r0_cnt", int'(count_out[0]), 0);
         chk("r0_flag", int'(rollover_flag[0]), 1);
         chk("r0_wp", int'(wrap_pulse[0]), 0);
      end

      rollover_val[0] = 4'd9;
      repeat (7) tick();
      chk("rlow_pre", int'(count_out[0]), 7);
      rollover_val[0] = 4'd4;
      tick();
      chk("rlow_cnt", int'(count_out[0]), 1);
      chk("rlow_wp", int'(wrap_pulse[0]), 1);
      count_enable[0] = 1'b0;
      tick();
      chk("rlow_wp_end", int'(wrap_pulse[0]), 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
